das_beam_accumulator: RTL

- Downstream of the per-channel weight multiplier. Consumes one signed product per channel per sample over a valid/ready stream.
- Sums NUM_CH products into one beam sample, then applies an arithmetic right shift and resizes the result to OUT_WIDTH.
- Emits the beam sample on a registered valid/ready output. Checks frame alignment against in_last.

---
 rtl/das_beam_accumulator.sv | 94 +++++++++
 1 files changed

// File: rtl/das_beam_accumulator.sv
// Sums NUM_CH signed channel products into one beam sample, shifts and resizes it,
// and checks frame alignment against in_last. Optional macro: DAS_BEAM_ACC_SAT_EN.
module das_beam_accumulator #(
    parameter int NUM_CH     = 4,
    parameter int PROD_WIDTH = 21,
    parameter int OUT_WIDTH  = 24,
    parameter int SHIFT      = 0
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic signed [PROD_WIDTH-1:0] in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_last,
    output logic signed [OUT_WIDTH-1:0]  out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         frame_err
);

    localparam int CNT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int AW    = PROD_WIDTH + $clog2(NUM_CH);
    localparam int WW    = ((AW > OUT_WIDTH) ? AW : OUT_WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CH = CNT_W'(NUM_CH - 1);
    localparam logic signed [WW-1:0] MAX_W =
        {{(WW - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [WW-1:0] MIN_W = ~MAX_W;

    logic signed [AW-1:0]        acc;
    logic [CNT_W-1:0]            ch_cnt;
    logic signed [AW-1:0]        sum;
    logic signed [AW-1:0]        shifted;
    logic signed [WW-1:0]        shifted_w;
    logic signed [WW-1:0]        clamped;
    logic signed [OUT_WIDTH-1:0] resized;
    logic                        beat;
    logic                        last_ch;

    // Only the final channel can stall: it is the only beat that overwrites out_data.
    assign last_ch  = (ch_cnt == LAST_CH);
    assign in_ready = !(last_ch && out_valid && !out_ready);
    assign beat     = in_valid && in_ready;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        sum       = acc + {{(AW - PROD_WIDTH){in_data[PROD_WIDTH-1]}}, in_data};
        shifted   = sum >>> SHIFT;
        shifted_w = {{(WW - AW){shifted[AW-1]}}, shifted};
        clamped   = shifted_w;
`ifdef DAS_BEAM_ACC_SAT_EN
        if (shifted_w > MAX_W) begin
            clamped = MAX_W;
        end else if (shifted_w < MIN_W) begin
            clamped = MIN_W;
        end
`endif
        resized = clamped[OUT_WIDTH-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            acc       <= '0;
            ch_cnt    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            frame_err <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (beat) begin
                if (last_ch) begin
                    out_data  <= resized;
                    out_valid <= 1'b1;
                    acc       <= '0;
                    ch_cnt    <= '0;
                    if (!in_last) begin
                        frame_err <= 1'b1;
                    end
                end else if (in_last) begin
                    // Short frame: drop the partial sum and resynchronise on the next beat.
                    acc       <= '0;
                    ch_cnt    <= '0;
                    frame_err <= 1'b1;
                end else begin
                    acc    <= sum;
                    ch_cnt <= ch_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule
